// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding,
// access-width codes and the default fetch starvation limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    localparam logic [1:0] WIDTH_B = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_W = 2'd2;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_be_gen.sv
// Byte-enable and store-lane replication for data-port accesses; also flags
// misaligned or illegal-width requests so they can bypass memory.
module mem_be_gen
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misaligned
);

    // Lane selection per access width; width code 3 is always rejected
    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0000_0000;
        misaligned = 1'b0;
        case (width)
            WIDTH_B: begin
                be         = 4'b0001 << addr;
                lane_wdata = {4{wdata[7:0]}};
            end
            WIDTH_H: begin
                be         = 4'b0011 << {addr[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
                misaligned = addr[0];
            end
            WIDTH_W: begin
                be         = 4'b1111;
                lane_wdata = wdata;
                misaligned = (addr != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch and data access, with data priority bounded by a starvation counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic        dm_we_i,
    input  logic [1:0]  dm_width_i,
    output logic        dm_gnt_o,
    output logic        dm_rvalid_o,
    output logic [31:0] dm_rdata_o,
    output logic        dm_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_r, next_state_s;
    logic [CNT_W-1:0]  starve_r;
    logic              if_gnt_s, dm_gnt_s, pick_if_s;
    logic [3:0]        be_s;
    logic [31:0]       lane_wdata_s;
    logic              misaligned_s;
    logic              owner_dm_r, err_r;
    logic [31:0]       resp_data_r;
    logic              mem_req_r, mem_we_r;
    logic [31:0]       mem_addr_r, mem_wdata_r;
    logic [3:0]        mem_be_r;
    logic              if_rvalid_r, dm_rvalid_r, dm_err_r;
    logic [31:0]       if_rdata_r, dm_rdata_r;

    mem_be_gen u_be_gen (
        .addr       (dm_addr_i[1:0]),
        .width      (dm_width_i),
        .wdata      (dm_wdata_i),
        .be         (be_s),
        .lane_wdata (lane_wdata_s),
        .misaligned (misaligned_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Grant decision and next-state; grants are gated by rst so reset silences them at once
    always_comb begin
        next_state_s = state_r;
        pick_if_s    = if_req_i && (!dm_req_i || (starve_r == LIMIT));
        if_gnt_s     = 1'b0;
        dm_gnt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if_gnt_s = !rst && pick_if_s;
                dm_gnt_s = !rst && dm_req_i && !pick_if_s;
                if (if_gnt_s) begin
                    next_state_s = BUSY_IF;
                end else if (dm_gnt_s) begin
                    next_state_s = misaligned_s ? RESP : BUSY_DM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack_i) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = state_r;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Fetch starvation counter, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= '0;
        end else if (!if_req_i || if_gnt_s) begin
            starve_r <= '0;
        end else if (dm_gnt_s && (starve_r != LIMIT)) begin
            starve_r <= starve_r + CNT_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // Memory-side request registers and response capture/delivery
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_dm_r  <= 1'b0;
            err_r       <= 1'b0;
            resp_data_r <= 32'h0000_0000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            if_rvalid_r <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            dm_rvalid_r <= 1'b0;
            dm_rdata_r  <= 32'h0000_0000;
            dm_err_r    <= 1'b0;
        end else begin
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            dm_err_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (if_gnt_s) begin
                        owner_dm_r  <= 1'b0;
                        err_r       <= 1'b0;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= if_addr_i & 32'hFFFF_FFFC;
                        mem_wdata_r <= 32'h0000_0000;
                        mem_be_r    <= 4'b1111;
                    end else if (dm_gnt_s) begin
                        owner_dm_r <= 1'b1;
                        err_r      <= misaligned_s;
                        // Rejected accesses never touch the memory port
                        if (!misaligned_s) begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= dm_we_i;
                            mem_addr_r  <= dm_addr_i & 32'hFFFF_FFFC;
                            mem_wdata_r <= lane_wdata_s;
                            mem_be_r    <= be_s;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ack_i) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        resp_data_r <= mem_rdata_i;
                    end
                end
                RESP: begin
                    if (owner_dm_r) begin
                        dm_rvalid_r <= 1'b1;
                        dm_err_r    <= err_r;
                        dm_rdata_r  <= err_r ? 32'h0000_0000 : resp_data_r;
                    end else begin
                        if_rvalid_r <= 1'b1;
                        if_rdata_r  <= resp_data_r;
                    end
                end
                default: begin
                    owner_dm_r <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt_o    = if_gnt_s;
    assign dm_gnt_o    = dm_gnt_s;
    assign if_rvalid_o = if_rvalid_r;
    assign if_rdata_o  = if_rdata_r;
    assign dm_rvalid_o = dm_rvalid_r;
    assign dm_rdata_o  = dm_rdata_r;
    assign dm_err_o    = dm_err_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign mem_be_o    = mem_be_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus pushes expected
// responses, a monitor pops and compares them when rvalid pulses.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o, dm_err_o;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic [1:0]  dm_width_i;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_we_i(dm_we_i), .dm_width_i(dm_width_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    resp_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    ack_delay = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [138:0] all_outputs();
        return {if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
                dm_err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
    endfunction

    // Memory model: ack after ack_delay cycles of mem_req_o, data = 0x5A5A0000 | addr[15:0]
    initial begin
        int          wait_cnt;
        logic [68:0] snap;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        wait_cnt    = 0;
        snap        = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o && !rst) begin
                if (wait_cnt == 0) snap = {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
                else check("mem_stable", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, snap);
                if (wait_cnt == ack_delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = 32'h5A5A_0000 | {16'h0000, mem_addr_o[15:0]};
                    wait_cnt    = 0;
                end else begin
                    mem_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'h0;
                wait_cnt    = 0;
            end
        end
    end

    // Monitor: every rvalid pulse must match the oldest expected response
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            check("gnt_onehot", {1'b0, if_gnt_o && dm_gnt_o}, 2'b00);
            if (if_rvalid_o || dm_rvalid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", {if_rvalid_o, dm_rvalid_o}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("rsp_owner", {if_rvalid_o, dm_rvalid_o}, {~e.is_dm, e.is_dm});
                    check("rsp_data", e.is_dm ? dm_rdata_o : if_rdata_o, e.data);
                    check("rsp_err", dm_err_o, e.err);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic await_grant(output logic got_dm, output int gcyc);
        bit ok = 1'b0;
        got_dm = 1'b0;
        gcyc   = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (if_gnt_o || dm_gnt_o) begin
                got_dm = dm_gnt_o;
                gcyc   = cyc;
                ok     = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("grant_timeout", 1'b0, 1'b1);
    endtask

    task automatic dm_set(input logic [31:0] a, input logic [1:0] w, input logic we, input logic [31:0] d);
        dm_req_i = 1'b1; dm_addr_i = a; dm_width_i = w; dm_we_i = we; dm_wdata_i = d;
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  width;
        logic        we;
        logic [31:0] wdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] lanes;
    } vec_t;

    vec_t vecs[6] = '{
        '{32'h0000_0203, 2'd0, 1'b1, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB},
        '{32'h0000_0302, 2'd1, 1'b1, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234},
        '{32'h0000_020D, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'b0010, 32'hEFEF_EFEF},
        '{32'h0000_0301, 2'd1, 1'b0, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000},
        '{32'h0000_0306, 2'd2, 1'b0, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000},
        '{32'h0000_0308, 2'd3, 1'b0, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000}
    };

    initial begin
        logic got_dm;
        int   g, g2;
        rst = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0;
        dm_req_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0; dm_we_i = 1'b0; dm_width_i = 2'd0;
        #2 rst = 1'b1;

        // Reset: outputs quiet even with both requests pending
        @(negedge clk);
        if_req_i = 1'b1; dm_req_i = 1'b1;
        #1 check("reset_outputs", all_outputs(), 139'd0);
        @(negedge clk);
        if_req_i = 1'b0; dm_req_i = 1'b0;
        rst = 1'b0;

        // Simultaneous fetch and word load: data first, fetch right after response
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
        dm_set(32'h0000_0104, 2'd2, 1'b0, 32'h0);
        await_grant(got_dm, g);
        check("both_first_owner", got_dm, 1'b1);
        sb.push_back('{1'b1, 32'h5A5A_0104, 1'b0, g + 3});
        @(negedge clk);
        dm_req_i = 1'b0;
        check("load_mem_req", mem_req_o, 1'b1);
        check("load_mem_addr", mem_addr_o, 32'h0000_0104);
        check("load_mem_be", mem_be_o, 4'hF);
        check("load_mem_we", mem_we_o, 1'b0);
        check("busy_no_gnt", {if_gnt_o, dm_gnt_o}, 2'b00);
        await_grant(got_dm, g2);
        check("both_second_owner", got_dm, 1'b0);
        check("if_gnt_cycle", g2, g + 3);
        sb.push_back('{1'b0, 32'h5A5A_0400, 1'b0, g2 + 3});
        @(negedge clk);
        if_req_i = 1'b0;
        repeat (4) @(negedge clk);

        // Lane/byte-enable table, including misaligned and illegal-width rejects
        foreach (vecs[i]) begin
            dm_set(vecs[i].addr, vecs[i].width, vecs[i].we, vecs[i].wdata);
            await_grant(got_dm, g);
            check("vec_owner", got_dm, 1'b1);
            if (vecs[i].err) sb.push_back('{1'b1, 32'h0, 1'b1, g + 2});
            else sb.push_back('{1'b1, 32'h5A5A_0000 | (vecs[i].addr & 32'h0000_FFFC), 1'b0, g + 3});
            @(negedge clk);
            dm_req_i = 1'b0;
            if (vecs[i].err) begin
                check("err_no_mem_req", mem_req_o, 1'b0);
            end else begin
                check("vec_mem_addr", mem_addr_o, vecs[i].addr & 32'hFFFF_FFFC);
                check("vec_mem_be", mem_be_o, vecs[i].be);
                check("vec_mem_wdata", mem_wdata_o, vecs[i].lanes);
                check("vec_mem_we", mem_we_o, 1'b1);
            end
            @(negedge clk);
            check("no_mem_req_late", mem_req_o, 1'b0);
            repeat (2) @(negedge clk);
        end

        // Starvation: data held back-to-back, fetch waits; fifth grant is fetch
        if_req_i = 1'b1; if_addr_i = 32'h0000_0700;
        dm_set(32'h0000_0500, 2'd2, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            await_grant(got_dm, g);
            check("starve_owner", got_dm, (k < 4) ? 1'b1 : 1'b0);
            if (k < 4) sb.push_back('{1'b1, 32'h5A5A_0000 | dm_addr_i, 1'b0, g + 3});
            else sb.push_back('{1'b0, 32'h5A5A_0700, 1'b0, g + 3});
            @(negedge clk);
            if (got_dm) dm_addr_i = dm_addr_i + 32'd4;
            else if_req_i = 1'b0;
        end
        await_grant(got_dm, g);
        check("post_starve_owner", got_dm, 1'b1);
        sb.push_back('{1'b1, 32'h5A5A_0000 | dm_addr_i, 1'b0, g + 3});
        @(negedge clk);
        dm_req_i = 1'b0; if_req_i = 1'b0;
        repeat (4) @(negedge clk);

        // Ack delayed by 5 cycles: one response, mem outputs held meanwhile
        ack_delay = 5;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0602;
        await_grant(got_dm, g);
        check("delay_owner", got_dm, 1'b0);
        sb.push_back('{1'b0, 32'h5A5A_0600, 1'b0, g + 8});
        @(negedge clk);
        if_req_i = 1'b0;
        check("delay_mem_addr", mem_addr_o, 32'h0000_0600);
        repeat (10) @(negedge clk);

        // Reset in BUSY_IF: everything drops at once and no response follows
        if_req_i = 1'b1; if_addr_i = 32'h0000_0800;
        await_grant(got_dm, g);
        @(negedge clk);
        if_req_i = 1'b0;
        @(negedge clk);
        check("busy_before_rst", mem_req_o, 1'b1);
        if_req_i = 1'b1; dm_req_i = 1'b1; rst = 1'b1;
        #1 check("rst_busy_outputs", all_outputs(), 139'd0);
        @(negedge clk);
        check("rst_hold_outputs", all_outputs(), 139'd0);
        if_req_i = 1'b0; dm_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        repeat (10) @(negedge clk);

        // Recovery after reset
        dm_set(32'h0000_0900, 2'd2, 1'b0, 32'h0);
        await_grant(got_dm, g);
        check("recover_owner", got_dm, 1'b1);
        sb.push_back('{1'b1, 32'h5A5A_0900, 1'b0, g + 3});
        @(negedge clk);
        dm_req_i = 1'b0;
        repeat (6) @(negedge clk);

        check("scoreboard_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive data-port grants allowed while fetch waits.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req_i  input  1  fetch read request, held until granted.
REQ-005 if_addr_i  input  32  fetch word address.
REQ-006 if_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid_o  output  1  one-cycle pulse: if_rdata_o valid.
REQ-008 if_rdata_o  output  32  fetched instruction word.
REQ-009 dm_req_i  input  1  data request from execute, held until granted.
REQ-010 dm_addr_i  input  32  data byte address.
REQ-011 dm_wdata_i  input  32  store data, low-aligned.
REQ-012 dm_we_i  input  1  1 = store, 0 = load.
REQ-013 dm_width_i  input  2  0 byte, 1 half, 2 word, 3 illegal.
REQ-014 dm_gnt_o  output  1  data request accepted this cycle.
REQ-015 dm_rvalid_o  output  1  one-cycle completion pulse (load data or store done).
REQ-016 dm_rdata_o  output  32  raw memory word for loads; lane extraction is done downstream.
REQ-017 dm_err_o  output  1  pulses with dm_rvalid_o on misaligned or illegal-width access.
REQ-018 mem_req_o, mem_we_o  output  1 each  memory request and write strobe.
REQ-019 mem_addr_o  output  32  word-aligned address (bits [1:0] = 0).
REQ-020 mem_wdata_o, mem_be_o  output  32 / 4  lane-replicated store data and byte enables.
REQ-021 mem_ack_i, mem_rdata_i  input  1 / 32  memory completion and read data, valid together.

Function
REQ-022 FSM states IDLE, BUSY_IF, BUSY_DM, RESP; one transaction outstanding at any time.
REQ-023 In IDLE, grant SHALL be combinational: dm wins if dm_req_i, unless starve count = STARVE_LIMIT and if_req_i, then fetch wins.
REQ-024 At most one of if_gnt_o/dm_gnt_o SHALL be high per cycle; both SHALL be 0 outside IDLE.
REQ-025 On grant, address/data/we/be SHALL be registered; next state BUSY_IF or BUSY_DM; mem_req_o asserts from the following cycle.
REQ-026 mem_req_o and all mem_* outputs SHALL hold stable until the cycle mem_ack_i = 1 is sampled; then go to RESP.
REQ-027 RESP SHALL last one cycle: the owner's rvalid pulses with mem_rdata_i registered at ack; next state IDLE. Minimum grant-to-rvalid latency = 3 cycles with same-cycle ack.
REQ-028 Byte enables: width 0 -> 4'b0001 << addr[1:0], data byte replicated x4; width 1 -> 4'b0011 << (2*addr[1]), half replicated x2; width 2 -> 4'b1111.
REQ-029 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or width 3: granted, no memory access, direct to RESP with dm_rvalid_o=1, dm_err_o=1, dm_rdata_o=0.
REQ-030 Starve counter: +1 (saturating at STARVE_LIMIT) on each dm grant while if_req_i = 1; cleared on any if grant or when if_req_i = 0.
REQ-031 mem_ack_i while not in BUSY_* SHALL be ignored.
REQ-032 if_rdata_o/dm_rdata_o SHALL hold their last value between pulses.

Reset
REQ-033 rst SHALL force IDLE, starve count 0, and every output to 0 immediately, abandoning any in-flight transaction without a response pulse.
REQ-034 The first grant after rst deassertion SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-035 Shared package SHALL hold the state encoding, width codes (WIDTH_B/H/W) and STARVE_LIMIT default.
REQ-036 Byte-enable and lane replication SHALL be a sub-module mem_be_gen (combinational, inputs addr[1:0], width, wdata; outputs be, wdata, misaligned).

Verification
REQ-037 Simultaneous if_req and dm_req (load, addr 0x104, width 2), ack same cycle -> dm_gnt first, mem_be_o=4'hF, dm_rvalid 3 cycles after grant, then if_gnt.
REQ-038 Store byte 0xAB at 0x203 -> mem_addr_o=0x200, mem_be_o=4'b1000, mem_wdata_o=0xABABABAB, mem_we_o=1.
REQ-039 dm_req held continuously with if_req high, STARVE_LIMIT=4 -> fifth grant goes to fetch.
REQ-040 Half load at 0x301 -> no mem_req_o, dm_rvalid_o=1 and dm_err_o=1 two cycles after grant.
REQ-041 mem_ack_i delayed 5 cycles -> mem_* outputs stable throughout, exactly one rvalid pulse.
REQ-042 rst asserted while in BUSY_IF -> all outputs 0 same cycle, no if_rvalid_o pulse afterwards.
